div_iter_unit: RTL

//  Parametrised iterative (radix-2, one quotient bit/cycle) integer divider for the execute stage.

---
 rtl/div_iter_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/div_iter_unit.sv
// Iterative radix-2 integer divider: one quotient bit per cycle, signed/unsigned, optional {R,Q}+rn accumulate.
// Optional feature macro DIV_EARLY_TERM_EN: skip CALC when |rm| < |rs| at accept.
module div_iter_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                signed_op,
  input  logic                acc,
  input  logic                set_flags,
  input  logic                wb,
  input  logic [WIDTH-1:0]    rn,
  input  logic [WIDTH-1:0]    rm,
  input  logic [WIDTH-1:0]    rs,
  input  logic [ADDR_W-1:0]   rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_s,
  output logic                out_wb,
  output logic [2*WIDTH-1:0]  out_result,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                div_by_zero
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q, rn_q;
  logic               qneg_q, rneg_q, acc_q, dz_q, s_q, wb_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               out_valid_q, out_s_q, out_wb_q, dz_out_q;
  logic [2*WIDTH-1:0] out_result_q;
  logic [ADDR_W-1:0]  out_addr_q;

  logic [WIDTH-1:0]   rm_abs_s, rs_abs_s, q_fix_s, r_fix_s;
  logic               rs_zero_s, skip_s, accept_s;
  logic [WIDTH:0]     trial_s;
  logic [2*WIDTH-1:0] res_s;

  // Operand magnitudes and the decision to bypass CALC for an incoming request
  always_comb begin
    if (signed_op && rm[WIDTH-1]) rm_abs_s = -rm;
    else                          rm_abs_s = rm;
    if (signed_op && rs[WIDTH-1]) rs_abs_s = -rs;
    else                          rs_abs_s = rs;
    rs_zero_s = (rs == {WIDTH{1'b0}});
`ifdef DIV_EARLY_TERM_EN
    skip_s = rs_zero_s || (rm_abs_s < rs_abs_s);
`else
    skip_s = rs_zero_s;
`endif
  end

  // Trial subtract for one CALC step, and sign/accumulate fix-up of the raw magnitudes
  always_comb begin
    trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (qneg_q) q_fix_s = -quo_q;
    else        q_fix_s = quo_q;
    if (rneg_q) r_fix_s = -rem_q;
    else        r_fix_s = rem_q;
    if (acc_q)  res_s = {r_fix_s, q_fix_s} + {{WIDTH{1'b0}}, rn_q};
    else        res_s = {r_fix_s, q_fix_s};
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; the DONE handoff may chain straight into the next operation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = skip_s ? FIX : CALC;
        else          state_d = IDLE;
      end
      CALC: begin
        if (cnt_q == CNT_LAST) state_d = FIX;
        else                   state_d = CALC;
      end
      FIX:  state_d = DONE;
      DONE: begin
        if (accept_s)       state_d = skip_s ? FIX : CALC;
        else if (out_ready) state_d = IDLE;
        else                state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request acceptance
  always_comb begin
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept_s = in_valid && in_ready;
  end

  // Operand capture and restoring-division datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= {CNT_W{1'b0}};
      rem_q  <= {WIDTH{1'b0}};
      quo_q  <= {WIDTH{1'b0}};
      dvs_q  <= {WIDTH{1'b0}};
      rn_q   <= {WIDTH{1'b0}};
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      acc_q  <= 1'b0;
      dz_q   <= 1'b0;
      s_q    <= 1'b0;
      wb_q   <= 1'b0;
      addr_q <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      cnt_q  <= {CNT_W{1'b0}};
      dvs_q  <= rs_abs_s;
      rem_q  <= skip_s ? rm_abs_s : {WIDTH{1'b0}};
      quo_q  <= skip_s ? {WIDTH{1'b0}} : rm_abs_s;
      qneg_q <= signed_op & (rm[WIDTH-1] ^ rs[WIDTH-1]);
      rneg_q <= signed_op & rm[WIDTH-1];
      rn_q   <= rn;
      acc_q  <= acc;
      dz_q   <= rs_zero_s;
      s_q    <= set_flags;
      wb_q   <= wb;
      addr_q <= rd;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (trial_s[WIDTH]) begin
        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= trial_s[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Result bundle registers: loaded in FIX, held until the consumer takes them
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      out_s_q      <= 1'b0;
      out_wb_q     <= 1'b0;
      dz_out_q     <= 1'b0;
      out_result_q <= {(2*WIDTH){1'b0}};
      out_addr_q   <= {ADDR_W{1'b0}};
    end else if (state_q == FIX) begin
      out_valid_q  <= 1'b1;
      out_s_q      <= s_q;
      out_wb_q     <= wb_q;
      dz_out_q     <= dz_q;
      out_result_q <= res_s;
      out_addr_q   <= addr_q;
    end else if (state_q == DONE && out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_s       = out_s_q;
  assign out_wb      = out_wb_q;
  assign out_result  = out_result_q;
  assign out_addr    = out_addr_q;
  assign div_by_zero = dz_out_q;
endmodule
